// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Asynchronous-serial receiver, 8N1, LSB first. The raw RX pin is brought
// into the clock domain by a two-flop synchronizer. Each bit is then sampled
// at its midpoint by a small state machine, and bad stop bits are flagged.
//
// Parameters
//   CLOCKS_PER_BAUD  clk cycles per bit (>= 4), default 100 MHz / 115200
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   rx               in   raw serial line, idle high, asynchronous to clk
//   data_o           out  [7:0] last correctly framed byte
//   valid_o          out  one-cycle pulse when data_o is updated
//   framing_error_o  out  one-cycle pulse when the stop bit is sampled low
//   busy_o           out  high while a frame is in START, DATA or STOP
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLOCKS_PER_BAUD = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       framing_error_o,
   output logic       busy_o
);

   localparam int CW = $clog2(CLOCKS_PER_BAUD);
   localparam int HALF = CLOCKS_PER_BAUD / 2;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BAUD - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic          r_rxMeta;
   logic          r_rxSync;
   logic [1:0]    r_primeSr;
   logic [CW-1:0] r_baudCnt;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;

   logic          w_rxS;
   logic          w_halfTick;
   logic          w_fullTick;
   logic          w_shiftEn;
   logic          w_loadByte;
   logic          w_frameErr;
   logic          w_clearCnt;

   assign w_rxS      = r_rxSync;
   assign w_halfTick = (r_baudCnt == HALF_LAST);
   assign w_fullTick = (r_baudCnt == FULL_LAST);

   // Two-flop synchronizer. Both flops reset to the idle level, so the line
   // looks idle until real pin samples have worked their way through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
      end else begin
         r_rxMeta <= rx;
         r_rxSync <= r_rxMeta;
      end
   end

   // Because the synchronizer resets to 1, its first two post-reset values
   // are fake idle levels rather than pin samples. This two-stage flag marks
   // when the synchronizer holds a genuine pin sample. Without it, a line
   // held low through reset would leave WAIT_IDLE on the fake 1 and start a
   // frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_primeSr <= 2'b00;
      end else begin
         r_primeSr <= {r_primeSr[0], 1'b1};
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= WAIT_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. START looks at the line half a bit after the falling
   // edge to reject glitches. DATA and STOP then look once per full bit
   // period, which puts each sample near the middle of its bit.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (!w_rxS) begin
               w_nextState = START;
            end
         end
         START: begin
            if (w_halfTick) begin
               w_nextState = w_rxS ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_fullTick && (r_bitIdx == 3'd7)) begin
               w_nextState = STOP;
            end
         end
         STOP: begin
            if (w_fullTick) begin
               w_nextState = w_rxS ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (w_rxS && r_primeSr[1]) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = WAIT_IDLE;
         end
      endcase
   end

   // Output and strobe decode. busy_o comes straight from the state. The
   // byte-load and framing strobes are registered below, so their pulses
   // land in the same cycle busy_o drops.
   always_comb begin
      busy_o     = 1'b0;
      w_shiftEn  = 1'b0;
      w_loadByte = 1'b0;
      w_frameErr = 1'b0;
      case (r_state)
         START: begin
            busy_o = 1'b1;
         end
         DATA: begin
            busy_o    = 1'b1;
            w_shiftEn = w_fullTick;
         end
         STOP: begin
            busy_o     = 1'b1;
            w_loadByte = w_fullTick && w_rxS;
            w_frameErr = w_fullTick && !w_rxS;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
      w_clearCnt = (r_state == IDLE) || (r_state == WAIT_IDLE) ||
                   (w_nextState != r_state) || w_shiftEn;
   end

   // Baud counter. It is held at zero while waiting for a start bit and
   // restarts on every state change and every sampled data bit. That makes
   // each sample position depend only on when its phase began.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baudCnt <= '0;
      end else if (w_clearCnt) begin
         r_baudCnt <= '0;
      end else begin
         r_baudCnt <= r_baudCnt + CNT_ONE;
      end
   end

   // Bit index and shift register. Data arrives LSB first and enters at the
   // MSB. After eight shifts, the first bit received has reached bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bitIdx <= 3'd0;
         r_shift  <= 8'h00;
      end else begin
         if (r_state == IDLE) begin
            r_bitIdx <= 3'd0;
         end else if (w_shiftEn) begin
            r_bitIdx <= r_bitIdx + 3'd1;
         end
         if (w_shiftEn) begin
            r_shift <= {w_rxS, r_shift[7:1]};
         end
      end
   end

   // Registered outputs. data_o only changes on a good frame, so a framing
   // error leaves the previous byte in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_o          <= 8'h00;
         valid_o         <= 1'b0;
         framing_error_o <= 1'b0;
      end else begin
         valid_o         <= w_loadByte;
         framing_error_o <= w_frameErr;
         if (w_loadByte) begin
            data_o <= r_shift;
         end
      end
   end

endmodule
